// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter in front of the UART transmitter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ          = 4;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_GAP_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 200000;

    // One shared counter serves both the gap and the timeout, so size it for the larger.
    function automatic int cnt_width(input int timeout_cycles, input int gap_cycles);
        int m;
        m = (timeout_cycles > gap_cycles) ? timeout_cycles : gap_cycles;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N_REQ.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     valid
);

    localparam int IDX_W = $clog2(N_REQ);

    int idx;

    // Scan from farthest to nearest so the nearest set bit after ptr is written last.
    always_comb begin
        winner = '0;
        valid  = |req;
        idx    = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (req[idx]) winner = IDX_W'(idx);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ byte producers, with gap and timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int N_REQ          = DEF_N_REQ,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done_o,
    output logic                     tx_send,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] cur_id,
    output logic                     timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, GAP_CYCLES);

    arb_state_e          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic                done_q;
    logic                done_rise;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;

    logic [N_REQ-1:0]    gnt_n;
    logic [N_REQ-1:0]    done_n;
    logic                send_n;
    logic [DATA_W-1:0]   data_n;
    logic [IDX_W-1:0]    id_n;
    logic                terr_n;
    logic                busy_n;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign done_rise = tx_done & ~done_q;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        gnt_n   = '0;
        done_n  = '0;
        send_n  = tx_send;
        data_n  = tx_data;
        id_n    = cur_id;
        terr_n  = 1'b0;
        case (state)
            IDLE: begin
                send_n = 1'b0;
                if (pick_vld) begin
                    gnt_n   = onehot(pick_idx);
                    send_n  = 1'b1;
                    data_n  = req_data[pick_idx*DATA_W +: DATA_W];
                    id_n    = pick_idx;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                // A real completion takes precedence over a timeout landing on the same cycle.
                if (done_rise) begin
                    send_n  = 1'b0;
                    done_n  = onehot(cur_id);
                    ptr_n   = cur_id;
                    cnt_n   = '0;
                    state_n = GAP;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    send_n  = 1'b0;
                    terr_n  = 1'b1;
                    ptr_n   = cur_id;
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                send_n = 1'b0;
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                send_n  = 1'b0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // Reset leaves ptr at the last index so requester 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= IDX_W'(N_REQ - 1);
            done_q      <= 1'b1;
            gnt         <= '0;
            done_o      <= '0;
            tx_send     <= 1'b0;
            tx_data     <= '0;
            cur_id      <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ptr         <= ptr_n;
            done_q      <= tx_done;
            gnt         <= gnt_n;
            done_o      <= done_n;
            tx_send     <= send_n;
            tx_data     <= data_n;
            cur_id      <= id_n;
            timeout_err <= terr_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one default instance and one with a short timeout.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;

    logic [3:0]  req, req_t;
    logic [31:0] req_data, req_data_t;
    logic [3:0]  gnt, gnt_t, done_o, done_o_t;
    logic        tx_send, tx_send_t;
    logic [7:0]  tx_data, tx_data_t;
    logic        tx_done, tx_done_t;
    logic        busy, busy_t;
    logic [1:0]  cur_id, cur_id_t;
    logic        timeout_err, timeout_err_t;

    int n_checks;
    int n_err;
    bit stable;
    logic [3:0] oh;

    uart_tx_arbiter #(
        .DATA_W(8), .N_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(200000)
    ) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .done_o(done_o), .tx_send(tx_send), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .cur_id(cur_id), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(
        .DATA_W(8), .N_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(50)
    ) u_to (
        .clk(clk), .rst(rst), .req(req_t), .req_data(req_data_t), .gnt(gnt_t),
        .done_o(done_o_t), .tx_send(tx_send_t), .tx_data(tx_data_t), .tx_done(tx_done_t),
        .busy(busy_t), .cur_id(cur_id_t), .timeout_err(timeout_err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input bit on_to, input logic [3:0] exp, input int exp_n, input string tag);
        int n;
        n = 0;
        while (((on_to ? gnt_t : gnt) == 4'b0000) && n < 200) begin
            tick();
            n++;
        end
        check({tag, " gnt"}, on_to ? gnt_t : gnt, exp);
        check({tag, " latency"}, n, exp_n);
    endtask

    task automatic frame(input logic [3:0] exp_done, input string tag);
        repeat (5) tick();
        tx_done = 1'b1;
        tick();
        check({tag, " done_o"}, done_o, exp_done);
        tx_done = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_err      = 0;
        rst        = 1'b0;
        req        = '0;
        req_t      = '0;
        req_data   = '0;
        req_data_t = '0;
        tx_done    = 1'b0;
        tx_done_t  = 1'b0;

        // Reset values
        #2 rst = 1'b1;
        #2;
        check("rst gnt", gnt, 0);
        check("rst done_o", done_o, 0);
        check("rst tx_send", tx_send, 0);
        check("rst tx_data", tx_data, 0);
        check("rst busy", busy, 0);
        check("rst cur_id", cur_id, 0);
        check("rst timeout_err", timeout_err, 0);
        check("rst tx_send_t", tx_send_t, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single request, done 100 cycles later
        req_data = 32'h0000_00A5;
        req      = 4'b0001;
        tick();
        check("t1 gnt", gnt, 4'b0001);
        check("t1 tx_send", tx_send, 1);
        check("t1 tx_data", tx_data, 8'hA5);
        check("t1 cur_id", cur_id, 0);
        check("t1 busy", busy, 1);
        req    = 4'b0000;
        stable = 1'b1;
        repeat (99) begin
            tick();
            if (tx_send !== 1'b1 || tx_data !== 8'hA5 || gnt !== 4'b0 || done_o !== 4'b0) stable = 1'b0;
        end
        check("t1 hold", stable, 1);
        tx_done = 1'b1;
        tick();
        check("t1 done_o", done_o, 4'b0001);
        check("t1 tx_send off", tx_send, 0);
        check("t1 busy in gap", busy, 1);
        tx_done = 1'b0;
        tick();
        check("t1 done_o pulse", done_o, 4'b0000);
        repeat (14) tick();
        check("t1 busy end gap", busy, 1);
        tick();
        check("t1 busy idle", busy, 0);

        // Round robin with all four requests held
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            wait_gnt(1'b0, oh, (k == 0) ? 1 : 17, $sformatf("t2 rr%0d", k));
            check($sformatf("t2 rr%0d data", k), tx_data, 8'h11 * ((k % 4) + 1));
            if (k == 4) req = 4'b0000;
            frame(oh, $sformatf("t2 rr%0d", k));
        end
        repeat (17) tick();

        // Contention after service: ptr=0 then ptr=1
        req_data = 32'h0000_BBAA;
        req      = 4'b0011;
        wait_gnt(1'b0, 4'b0010, 1, "t3 ptr0");
        check("t3 ptr0 data", tx_data, 8'hBB);
        frame(4'b0010, "t3 ptr0");
        wait_gnt(1'b0, 4'b0001, 17, "t3 ptr1");
        check("t3 ptr1 data", tx_data, 8'hAA);
        req = 4'b0000;
        frame(4'b0001, "t3 ptr1");
        repeat (17) tick();

        // Level tx_done held high between frames
        req_data = 32'h00CC_0000;
        req      = 4'b0100;
        wait_gnt(1'b0, 4'b0100, 1, "t4 f1");
        repeat (5) tick();
        tx_done = 1'b1;
        tick();
        check("t4 f1 done_o", done_o, 4'b0100);
        wait_gnt(1'b0, 4'b0100, 17, "t4 f2");
        req    = 4'b0000;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (done_o !== 4'b0) stable = 1'b0;
        end
        check("t4 no early done", stable, 1);
        check("t4 still sending", tx_send, 1);
        tx_done = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        check("t4 f2 done_o", done_o, 4'b0100);
        tx_done = 1'b0;
        repeat (17) tick();

        // Timeout on the short-timeout instance
        req_data_t = 32'h0000_6B5A;
        req_t      = 4'b0001;
        wait_gnt(1'b1, 4'b0001, 1, "t5 first");
        check("t5 tx_send", tx_send_t, 1);
        req_t = 4'b0010;
        repeat (49) tick();
        check("t5 terr early", timeout_err_t, 0);
        check("t5 send early", tx_send_t, 1);
        tick();
        check("t5 terr", timeout_err_t, 1);
        check("t5 send off", tx_send_t, 0);
        check("t5 no done", done_o_t, 0);
        tick();
        check("t5 terr pulse", timeout_err_t, 0);
        wait_gnt(1'b1, 4'b0010, 16, "t5 next");
        check("t5 next data", tx_data_t, 8'h6B);
        req_t = 4'b0000;

        // Reset in the middle of SEND
        req_data = 32'hDD00_0000;
        req      = 4'b1000;
        wait_gnt(1'b0, 4'b1000, 1, "t6 pre");
        req = 4'b0000;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("t6 tx_send async", tx_send, 0);
        check("t6 busy async", busy, 0);
        check("t6 gnt async", gnt, 0);
        check("t6 cur_id async", cur_id, 0);
        @(negedge clk);
        rst    = 1'b0;
        stable = 1'b1;
        repeat (3) begin
            tick();
            if (done_o !== 4'b0 || timeout_err !== 1'b0 || tx_send !== 1'b0) stable = 1'b0;
        end
        check("t6 quiet after rst", stable, 1);
        req_data = 32'h00EE_00FF;
        req      = 4'b0101;
        wait_gnt(1'b0, 4'b0001, 1, "t6 ptr reset");
        check("t6 data", tx_data, 8'hFF);
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        wait_gnt(1'b0, 4'b0100, 1, "t6 req2");
        check("t6 req2 data", tx_data, 8'hEE);
        req = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single transmitter inside uart_top between N_REQ byte producers. It arbitrates pending requests round-robin, latches the winner's byte, and drives the transmitter's send/data inputs. It then waits for the transmitter's done indication, returns per-requester completion, and enforces an inter-frame gap. A timeout recovers the arbiter if the transmitter never reports done.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must match the uart_top transmit data width
GAP_CYCLES, 16, idle clk cycles enforced after each frame before the next grant (>=1)
TIMEOUT_CYCLES, 200000, max clk cycles in SEND waiting for done before abort

Ports:
clk  input  1  system clock, same clock that feeds uart_top
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  level request per requester; held until gnt seen
req_data  input  N_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
gnt  output  N_REQ  one-hot, single-cycle pulse: request accepted and data latched
done_o  output  N_REQ  one-hot, single-cycle pulse: granted byte fully transmitted
tx_send  output  1  to uart_top send input
tx_data  output  DATA_W  to uart_top transmit data input
tx_done  input  1  from uart_top transmit-done output (level or pulse)
busy  output  1  high in SEND and GAP
cur_id  output  $clog2(N_REQ)  index of the current/last granted requester
timeout_err  output  1  single-cycle pulse on transmit timeout

Behaviour:
- Reset (async, active-high), all asserted immediately:
  - state=IDLE; gnt=0; done_o=0; tx_send=0; tx_data=0; busy=0; cur_id=0; timeout_err=0.
  - Round-robin pointer ptr=N_REQ-1, so req[0] has first priority.
  - done_q (tx_done delay register)=1, so a tx_done already high after reset is not seen as an edge.
  - gap/timeout counter=0.
- Edge detect: done_rise = tx_done & ~done_q; done_q updates every cycle in every state.
- IDLE:
  - If req!=0, winner = first set bit searching ptr+1, ptr+2, ... modulo N_REQ.
  - Next edge: gnt[winner]=1 for one cycle, tx_data=req_data[winner], tx_send=1, cur_id=winner, counter=0, state=SEND.
  - Latency: req sampled at edge k, so gnt and tx_send are high after edge k+1.
  - If req==0, stay in IDLE; outputs are 0, tx_data holds its last value.
- SEND:
  - tx_send and tx_data held stable.
  - req and req_data are ignored; a requester dropping req has no effect.
  - On done_rise: tx_send=0, done_o[cur_id]=1 for one cycle, ptr=cur_id, counter=0, state=GAP.
  - Else if counter==TIMEOUT_CYCLES-1: tx_send=0, timeout_err=1 for one cycle, no done_o, ptr=cur_id, counter=0, state=GAP.
  - Else counter increments.
  - done_rise wins over timeout if both occur in the same cycle.
- GAP:
  - busy=1, tx_send=0.
  - Counter increments; at counter==GAP_CYCLES-1, state=IDLE.
  - Requests pending during GAP are arbitrated in the first IDLE cycle.
- Fairness:
  - A requester holding req continuously is served again only after every other pending requester has been served once.
  - A requester that keeps req high after gnt is treated as a new request.
- Reset mid-SEND: tx_send drops immediately, no done_o or timeout_err is produced, and the byte is lost. The requester already received gnt and must resend.
- gnt and done_o are never high for more than one bit or more than one cycle. gnt and done_o for the same id are never in the same cycle.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, SEND, GAP), counter width as $clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)), default constants.
- One combinational sub-module rr_picker:
  - Inputs: req vector, ptr.
  - Outputs: winner index, valid.
  - Separately unit-testable.

Test Plan:
- Single request: req=0001, req_data[7:0]=8'hA5, tx_done pulsed 100 cycles later -> gnt=0001 and tx_send=1 one cycle after req; tx_data=8'hA5 stable; done_o=0001 one cycle after tx_done rises; busy low exactly GAP_CYCLES cycles later.
- Round-robin: req=1111 held continuously, bytes 8'h11/22/33/44 -> grant order 0,1,2,3,0; each gnt separated by one frame plus GAP_CYCLES.
- Contention after service: ptr=1, req=0011 -> requester 0 wins before 1; then ptr=0, req=0011 -> requester 1 wins.
- Level tx_done: tx_done stays high between frames -> no done_o until it falls and rises again; a second frame does not complete immediately.
- Timeout: TIMEOUT_CYCLES=50, tx_done held 0 -> timeout_err pulses 50 cycles after tx_send rises; tx_send=0; no done_o; next requester is granted after the gap.
- Reset mid-SEND: rst asserted 10 cycles into SEND -> tx_send, busy, gnt low asynchronously; after release, req=0100 -> requester 2 is granted (ptr reset to N_REQ-1).
